// File: rtl/dpic_imem_pipe.sv
// dpic_imem_pipe: simulation instruction-memory model behind a valid/ready fetch
// interface. Each accepted aligned fetch reads the memory image once
// (dpic_imem_read), travels a LATENCY-deep delay line and lands in a DEPTH-entry
// in-order response queue. Misaligned fetches return err=1 and inst=0 without
// reading the memory.
// Latency: a request accepted at edge N is first visible on resp_* after edge N+LATENCY.
// Backpressure: req_ready drops when DEPTH requests are outstanding. The credit
// count means the queue can never overflow, so the delay line itself never stalls.
// Ports:
//   clock, reset             : clock, synchronous active-high reset
//   req_valid/req_ready/req_pc : fetch request channel
//   resp_valid/resp_ready    : response channel, head of queue
//   resp_inst/resp_pc/resp_err : head payload, driven to zero while the queue is empty
//   flush                    : drops every outstanding request and response
//   busy                     : at least one request is outstanding
module dpic_imem_pipe #(
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LATENCY    = 2,   // 1..8
  parameter int DEPTH      = 4    // power of two, >= 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_pc,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [INST_WIDTH-1:0] resp_inst,
  output logic [ADDR_WIDTH-1:0] resp_pc,
  output logic                  resp_err,
  input  logic                  flush,
  output logic                  busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Behavioural stand-in for the C++ memory model, so the block elaborates
  // on its own. The image is "addi s0, zero, k". k is the word offset from
  // 0x80000000, folded with the upper address bits. Every address bit feeds
  // the result.
  function automatic logic [INST_WIDTH-1:0] dpic_imem_read(input logic [ADDR_WIDTH-1:0] pc);
    logic [31:0] p;
    logic [11:0] imm;
    p   = 32'(pc);
    imm = p[13:2] ^ p[25:14] ^ {6'd0, p[31:26] ^ 6'h20} ^ {10'd0, p[1:0]};
    return INST_WIDTH'({imm, 20'h00413});
  endfunction

  // Outstanding-request credit count.
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;
  logic          pop;
  logic          misalign;

  // Delay line.
  logic [LATENCY-1:0]    stg_vld_q;
  logic [LATENCY-1:0]    stg_err_q;
  logic [ADDR_WIDTH-1:0] stg_pc_q   [LATENCY];
  logic [INST_WIDTH-1:0] stg_inst_q [LATENCY];

  // Response queue. The pointers carry one extra wrap bit, so full and empty
  // can be told apart.
  logic [DEPTH-1:0]      q_err_q;
  logic [ADDR_WIDTH-1:0] q_pc_q   [DEPTH];
  logic [INST_WIDTH-1:0] q_inst_q [DEPTH];
  logic [CW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]         wr_idx, rd_idx;
  logic                  q_empty;
  logic                  q_wr;

  assign wr_idx   = wr_ptr_q[PW-1:0];
  assign rd_idx   = rd_ptr_q[PW-1:0];
  assign q_empty  = (wr_ptr_q == rd_ptr_q);
  assign misalign = |req_pc[1:0];

  // Ready depends only on state, flush and reset, never on req_valid.
  // A pop in this cycle does not free a credit until the next edge.
  assign req_ready = !reset && !flush && (cnt_q < CW'(DEPTH));
  assign accept    = req_valid && req_ready;

  assign resp_valid = !q_empty;
  // A response shown during flush is discarded, not consumed.
  assign pop        = resp_valid && resp_ready && !flush;
  assign busy       = (cnt_q != '0);

  assign resp_pc   = resp_valid ? q_pc_q[rd_idx]   : '0;
  assign resp_inst = resp_valid ? q_inst_q[rd_idx] : '0;
  assign resp_err  = resp_valid ? q_err_q[rd_idx]  : 1'b0;

  // An entry leaving the last delay stage is written into the queue.
  // During flush it is dropped with everything else.
  assign q_wr = stg_vld_q[LATENCY-1] && !flush;

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (accept && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !accept) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The valid bits advance every cycle; nothing downstream can stall them.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      stg_vld_q <= '0;
    end else begin
      stg_vld_q[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        stg_vld_q[i] <= stg_vld_q[i-1];
      end
    end
  end

  // The memory is read exactly once, on the accepting edge, and only for
  // aligned addresses.
  always_ff @(posedge clock) begin
    if (!reset && accept) begin
      stg_pc_q[0]  <= req_pc;
      stg_err_q[0] <= misalign;
      if (misalign) begin
        stg_inst_q[0] <= '0;
      end else begin
        stg_inst_q[0] <= dpic_imem_read(req_pc);
      end
    end
    for (int i = 1; i < LATENCY; i++) begin
      stg_pc_q[i]   <= stg_pc_q[i-1];
      stg_err_q[i]  <= stg_err_q[i-1];
      stg_inst_q[i] <= stg_inst_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (q_wr) begin
        wr_ptr_q <= wr_ptr_q + CW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + CW'(1);
      end
    end
  end

  // Queue storage is not reset. The outputs are gated by resp_valid, so
  // stale entries are never visible.
  always_ff @(posedge clock) begin
    if (!reset && q_wr) begin
      q_pc_q[wr_idx]   <= stg_pc_q[LATENCY-1];
      q_inst_q[wr_idx] <= stg_inst_q[LATENCY-1];
      q_err_q[wr_idx]  <= stg_err_q[LATENCY-1];
    end
  end

endmodule
